mc_datapath: RTL
================

Name: mc_datapath

Overview:
- Parametrised multi-cycle successor to the single-cycle 16-bit datapath.
- Executes one instruction over several states: FETCH, DECODE, EXEC, MEM, WB.
- Instruction and data memories are external and reached through req/ack handshakes, so wait states are tolerated.
- Control signals still come from the external chip controller, which decodes the opcode output. Data width and register count are parameters.

Parameters:
- DATA_W, 16, datapath/PC/register width; must be >=16.
- NREG_W, 3, register index width; the register file holds 2**NREG_W entries. Instruction fields stay 3 bits and are zero-extended.
- PC_RESET, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- opcode  out  4  IR[15:12]
- reg_dst, alu_src, mem_to_reg, reg_w, mem_r, mem_w, beq, bne, j  in  1 each  decoded controls
- alu_op  in  2  ALU class: 00 add, 01 sub, 10 function from opcode
- imem_req  out  1  fetch request
- imem_addr  out  DATA_W  fetch address (=PC)
- imem_rdata  in  16  instruction
- imem_ack  in  1  instruction valid
- dmem_req  out  1  data request
- dmem_we  out  1  1=store
- dmem_addr  out  DATA_W  ALUOut
- dmem_wdata  out  DATA_W  B register
- dmem_rdata  in  DATA_W  load data
- dmem_ack  in  1  data access complete
- halt  in  1  stop at instruction boundary
- retire  out  1  one-cycle pulse per completed instruction
- state  out  3  current FSM state (debug)

Behaviour:
- Reset, asynchronous:
  - state=FETCH, PC=PC_RESET, IR=0.
  - A/B/ALUOut/MDR=0, all registers=0.
  - imem_req=dmem_req=dmem_we=retire=0.
  - Reset mid-handshake drops req immediately; no register or memory write completes.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - If halt=1 on entry (req not yet raised), go to HALT.
  - Otherwise imem_req=1, with imem_addr held at PC until the cycle where imem_ack=1.
  - On that cycle: IR<=imem_rdata, PC<=PC+2 (mod 2**DATA_W), go to DECODE.
  - An ack while req=0 is ignored.
- DECODE:
  - A<=R[IR[11:9]], B<=R[IR[8:6]].
  - Controls are sampled from this state onward and are assumed stable while IR is stable.
  - Go to EXEC.
- EXEC:
  - b = alu_src ? immext : B, where immext = sign-extend IR[5:0] to DATA_W.
  - ALUOut<=f(A,b). Functions:
    - alu_op 00: add; alu_op 01: sub.
    - alu_op 10 by opcode: 2 add, 3 sub, 4 and, 5 or, 6 slt (signed, result 0/1), 7 shl by b[3:0], 8 shr logical by b[3:0]; any other opcode gives 0.
  - iszero = (A-b)==0.
  - j=1: PC<={PC[DATA_W-1:13],IR[11:0],0}, retire, go to FETCH.
  - beq&iszero or bne&~iszero: PC<=PC+immext.
  - Untaken branch: PC unchanged.
  - A branch, taken or not, retires and goes to FETCH.
  - Otherwise go to MEM if mem_r|mem_w, else to WB if reg_w, else retire and go to FETCH.
- MEM:
  - dmem_req=1, dmem_we=mem_w, address and data held stable until dmem_ack.
  - On ack: a load sets MDR<=dmem_rdata and goes to WB; a store retires and goes to FETCH.
- WB:
  - R[ws]<=mem_to_reg ? MDR : ALUOut.
  - ws = reg_dst ? IR[5:3] : IR[8:6].
  - Retire, go to FETCH.
- HALT: outputs idle; when halt=0, go to FETCH. PC is preserved.
- retire is registered and asserts for exactly one cycle on the transition out of the final state.
- Latency with zero-wait ack (FETCH through retire):
  - R-type/addi: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/jump: 3 cycles.
  - Each wait cycle adds one.
- R0 is an ordinary writable register.

Decomposition:
- Package mc_pkg holds:
  - state enum;
  - ALU function codes;
  - field positions (OPC_MSB=15, RS1=11:9, RS2=8:6, RD=5:3, IMM=5:0, JT=11:0);
  - instruction width 16.
- Sub-module gpr_param(DATA_W, NREG_W):
  - 2 asynchronous read ports, 1 synchronous write port;
  - asynchronous reset to zero.
- ALU and sequencer are inline.

Test Plan:
- Reset with PC_RESET=0, immediate acks, program "addi r1,r0,5; add r2,r1,r1" → r1=5, then r2=10. retire pulses on cycles 4 and 8; PC=4.
- Store r2 to address 0x20, then load it into r3 with 2-cycle dmem_ack delay → dmem_addr=0x20, dmem_wdata=10. req holds for 3 cycles; the load takes 7 cycles; r3=10.
- Branch tests:
  - beq r1,r1,-4 at PC=8 → PC=6 after 3 cycles.
  - bne r1,r1 untaken → PC=10.
  - j 0x100 at PC=0x0A → PC=0x200.
- PC=0xFFFE with DATA_W=16, fetch → PC wraps to 0x0000. A stray imem_ack while req=0 causes no IR change.
- halt=1 held across a retire → enters HALT, no imem_req. Releasing halt resumes fetch at the preserved PC.
- rst asserted mid-MEM of a store with dmem_ack not yet seen → dmem_req drops asynchronously, state=FETCH, PC=PC_RESET, destination unchanged.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle datapath: FSM state encoding,
// ALU class/function codes and instruction field positions.
package mc_pkg;

  localparam int INSTR_W = 16;

  // Instruction field positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RS1_MSB = 11;
  localparam int RS1_LSB = 9;
  localparam int RS2_MSB = 8;
  localparam int RS2_LSB = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int IMM_MSB = 5;
  localparam int IMM_W   = 6;
  localparam int JT_MSB  = 11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // ALU class from the controller
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  // Opcode-selected functions when the class is ALU_FUNC
  localparam logic [3:0] FN_ADD = 4'd2;
  localparam logic [3:0] FN_SUB = 4'd3;
  localparam logic [3:0] FN_AND = 4'd4;
  localparam logic [3:0] FN_OR  = 4'd5;
  localparam logic [3:0] FN_SLT = 4'd6;
  localparam logic [3:0] FN_SHL = 4'd7;
  localparam logic [3:0] FN_SHR = 4'd8;

endpackage

// File: rtl/mc_datapath_gpr.sv
// Parameterised register file: 2**NREG_W entries of DATA_W bits.
// Ports: clk/rst (async, active-high, clears all entries),
//   ra1_i/ra2_i -> rd1_o/rd2_o  asynchronous read ports,
//   we_i/wa_i/wd_i              synchronous write port.
module gpr_param
  import mc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREG_W-1:0] ra1_i,
  input  logic [NREG_W-1:0] ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              we_i,
  input  logic [NREG_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  localparam int NREG = 1 << NREG_W;

  logic [NREG-1:0][DATA_W-1:0] regs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       regs_q       <= '0;
    else if (we_i) regs_q[wa_i] <= wd_i;
  end

  assign rd1_o = regs_q[ra1_i];
  assign rd2_o = regs_q[ra2_i];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: FETCH/DECODE/EXEC/MEM/WB sequencer with handshaked
// instruction and data memories. Controls come from an external decoder
// that watches opcode.
// Ports: clk/rst (async, active-high); opcode out; decoded controls in;
//   imem_req/addr/rdata/ack fetch handshake; dmem_req/we/addr/wdata/rdata/ack
//   data handshake; halt stops at an instruction boundary; retire pulses once
//   per completed instruction; state exposes the FSM for debug.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                NREG_W   = 3,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [3:0]         opcode,
  input  logic               reg_dst,
  input  logic               alu_src,
  input  logic               mem_to_reg,
  input  logic               reg_w,
  input  logic               mem_r,
  input  logic               mem_w,
  input  logic               beq,
  input  logic               bne,
  input  logic               j,
  input  logic [1:0]         alu_op,
  output logic               imem_req,
  output logic [DATA_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  input  logic               halt,
  output logic               retire,
  output logic [2:0]         state
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   pc_q, pc_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                ireq_q, ireq_d;   // fetch request already raised
  logic                retire_q, retire_d;

  logic [DATA_W-1:0]   rd1, rd2, immext, bsel, diff, alu_res, rf_wd;
  logic                iszero, slt, rf_we;
  logic [NREG_W-1:0]   rf_wa;

  gpr_param #(.DATA_W(DATA_W), .NREG_W(NREG_W)) u_gpr (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (NREG_W'(ir_q[RS1_MSB:RS1_LSB])),
    .ra2_i (NREG_W'(ir_q[RS2_MSB:RS2_LSB])),
    .rd1_o (rd1),
    .rd2_o (rd2),
    .we_i  (rf_we),
    .wa_i  (rf_wa),
    .wd_i  (rf_wd)
  );

  assign opcode = ir_q[OPC_MSB:OPC_LSB];
  assign immext = {{(DATA_W-IMM_W){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:0]};
  assign bsel   = alu_src ? immext : b_q;
  assign diff   = a_q - bsel;
  assign iszero = (diff == '0);
  assign slt    = $signed(a_q) < $signed(bsel);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = a_q + bsel;
      ALU_SUB: alu_res = diff;
      ALU_FUNC: begin
        case (opcode)
          FN_ADD:  alu_res = a_q + bsel;
          FN_SUB:  alu_res = diff;
          FN_AND:  alu_res = a_q & bsel;
          FN_OR:   alu_res = a_q | bsel;
          FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, slt};
          FN_SHL:  alu_res = a_q << bsel[3:0];
          FN_SHR:  alu_res = a_q >> bsel[3:0];
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  assign rf_wa = reg_dst ? NREG_W'(ir_q[RD_MSB:RD_LSB]) : NREG_W'(ir_q[RS2_MSB:RS2_LSB]);
  assign rf_wd = mem_to_reg ? mdr_q : alu_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      ireq_q   <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      ireq_q   <= ireq_d;
      retire_q <= retire_d;
    end
  end

  // Next-state
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    ireq_d   = ireq_q;
    retire_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        // halt is honoured only before the request goes out; once raised,
        // the fetch must complete so the handshake is never abandoned.
        if (!ireq_q && halt) begin
          state_d = S_HALT;
        end else if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + DATA_W'(2);
          ireq_d  = 1'b0;
          state_d = S_DECODE;
        end else begin
          ireq_d  = 1'b1;
        end
      end
      S_DECODE: begin
        a_d     = rd1;
        b_d     = rd2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d = alu_res;
        if (j) begin
          pc_d     = {pc_q[DATA_W-1:13], ir_q[JT_MSB:0], 1'b0};
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else if (beq || bne) begin
          if ((beq && iszero) || (bne && !iszero)) pc_d = pc_q + immext;
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else if (mem_r || mem_w) begin
          state_d  = S_MEM;
        end else if (reg_w) begin
          state_d  = S_WB;
        end else begin
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (mem_w) begin
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d    = dmem_rdata;
            state_d  = S_WB;
          end
        end
      end
      S_WB: begin
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  if (!halt) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs; requests are gated by rst so they drop the moment reset hits.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      S_FETCH: imem_req = !rst && (ireq_q || !halt);
      S_MEM: begin
        dmem_req = !rst;
        dmem_we  = !rst && mem_w;
      end
      S_WB:    rf_we = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = alu_q;
  assign dmem_wdata = b_q;
  assign retire     = retire_q;
  assign state      = state_q;

endmodule
